// File: rtl/pc_seq_pkg.sv
// Shared encodings and helpers for the program-counter stage.
package pc_seq_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JAL  = 3'd2,
    SEL_JALR = 3'd3,
    SEL_HOLD = 3'd4
  } pc_sel_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: target adders, priority select and redirect alignment check.
module pc_next_mux
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  output pc_sel_e     sel,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] rel_tgt_s;
  logic [31:0] jalr_sum_s;
  logic [31:0] jalr_tgt_s;
  logic [31:0] target_s;
  logic        redirect_s;

  assign rel_tgt_s  = pc + imm;
  assign jalr_sum_s = rs1_data + imm;
  assign jalr_tgt_s = {jalr_sum_s[31:1], 1'b0};

  // Priority encode the redirect source; halt outranks every redirect.
  always_comb begin
    sel = SEL_SEQ;
    if (halt) begin
      sel = SEL_HOLD;
    end else if (jalr) begin
      sel = SEL_JALR;
    end else if (jal) begin
      sel = SEL_JAL;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end else begin
      sel = SEL_SEQ;
    end
  end

  // Route the selected target.
  always_comb begin
    target_s = pc_plus4;
    case (sel)
      SEL_HOLD:        target_s = pc;
      SEL_JALR:        target_s = jalr_tgt_s;
      SEL_JAL, SEL_BR: target_s = rel_tgt_s;
      SEL_SEQ:         target_s = pc_plus4;
      default:         target_s = pc_plus4;
    endcase
  end

  assign redirect_s = (sel == SEL_JALR) || (sel == SEL_JAL) || (sel == SEL_BR);
  assign misalign   = redirect_s & target_s[1];
  assign next_pc    = align_pc(target_s);

endmodule

// File: rtl/pc_sequencer.sv
// RV32I program-counter stage with RUN/HALT control and retire statistics.
// Statistics counters are built only when PC_STATS_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Halt,
  input  logic             BranchTaken,
  input  logic             Jal,
  input  logic             Jalr,
  input  logic [31:0]      Imm,
  input  logic [31:0]      Rs1Data,
  output logic [31:0]      Pc,
  output logic [31:0]      PcPlus4,
  output logic             Halted,
  output logic             Misalign,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] JumpCnt
);

  pc_state_e   state_r;
  pc_sel_e     sel_s;
  logic [31:0] next_pc_s;
  logic        mis_s;
  logic        run_s;

  assign PcPlus4 = Pc + PC_STEP;
  assign run_s   = (state_r == ST_RUN);

  pc_next_mux u_next_mux (
    .pc           (Pc),
    .pc_plus4     (PcPlus4),
    .imm          (Imm),
    .rs1_data     (Rs1Data),
    .halt         (Halt),
    .branch_taken (BranchTaken),
    .jal          (Jal),
    .jalr         (Jalr),
    .sel          (sel_s),
    .next_pc      (next_pc_s),
    .misalign     (mis_s)
  );

  // PC register and RUN/HALT state machine; HALT only listens to Go.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r  <= ST_RUN;
      Pc       <= RESET_PC;
      Halted   <= 1'b0;
      Misalign <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          Pc <= next_pc_s;
          if (mis_s) begin
            Misalign <= 1'b1;
          end
          if (sel_s == SEL_HOLD) begin
            state_r <= ST_HALT;
            Halted  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (Go) begin
            state_r <= ST_RUN;
            Halted  <= 1'b0;
            Pc      <= align_pc(PcPlus4);
          end
        end
        default: begin
          state_r <= ST_RUN;
          Halted  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_STATS_EN
  // Retire statistics; a halting instruction only counts as a cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      CycleCnt  <= '0;
      BranchCnt <= '0;
      JumpCnt   <= '0;
    end else if (run_s) begin
      CycleCnt <= CycleCnt + CNT_W'(1);
      if (sel_s == SEL_BR) begin
        BranchCnt <= BranchCnt + CNT_W'(1);
      end
      if ((sel_s == SEL_JAL) || (sel_s == SEL_JALR)) begin
        JumpCnt <= JumpCnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_s;
  assign unused_s  = run_s;
  assign CycleCnt  = '0;
  assign BranchCnt = '0;
  assign JumpCnt   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a behavioural PC/FSM model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst, go, halt, br, jal, jalr;
  logic [31:0] imm, rs1;
  logic [31:0] pc, pc4, cyc, brc, jmp;
  logic        halted, mis;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_pc, m_cyc, m_brc, m_jmp;
  logic        m_halted, m_mis;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .Clock(clk), .Reset(rst), .Go(go), .Halt(halt), .BranchTaken(br),
    .Jal(jal), .Jalr(jalr), .Imm(imm), .Rs1Data(rs1),
    .Pc(pc), .PcPlus4(pc4), .Halted(halted), .Misalign(mis),
    .CycleCnt(cyc), .BranchCnt(brc), .JumpCnt(jmp)
  );

  task automatic model_step();
    logic [31:0] t;
    bit          redir;
    if (rst) begin
      m_pc = RST_PC; m_halted = 1'b0; m_mis = 1'b0;
      m_cyc = 32'd0; m_brc = 32'd0; m_jmp = 32'd0;
    end else if (m_halted) begin
      if (go) begin
        m_pc = m_pc + 32'd4;
        m_halted = 1'b0;
      end
    end else begin
      m_cyc = m_cyc + 32'd1;
      if (halt) begin
        m_halted = 1'b1;
      end else begin
        redir = 1'b1;
        if (jalr)    t = (rs1 + imm) & ~32'd1;
        else if (jal) t = m_pc + imm;
        else if (br)  t = m_pc + imm;
        else begin t = m_pc + 32'd4; redir = 1'b0; end
        if (redir && t[1]) m_mis = 1'b1;
        m_pc = t & ~32'd3;
        if (jal || jalr) m_jmp = m_jmp + 32'd1;
        else if (br)     m_brc = m_brc + 32'd1;
      end
    end
`ifndef PC_STATS_EN
    m_cyc = 32'd0; m_brc = 32'd0; m_jmp = 32'd0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; go = 1'b0; halt = 1'b0; br = 1'b0; jal = 1'b0; jalr = 1'b0;
    imm = 32'd0; rs1 = 32'd0;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    idle_inputs(); jalr = 1'b1; rs1 = addr; tick(); idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    checks++; if ({halted, mis} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {halted, mis}); end
    checks++; if ({cyc, brc, jmp} !== 96'd0) begin errors++; $display("FAIL reset_cnt: got %h %h %h want 0", cyc, brc, jmp); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== RST_PC + 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, RST_PC + 32'(4 * i)); end
      checks++; if (pc4 !== pc + 32'd4) begin errors++; $display("FAIL pcplus4: got %h want %h", pc4, pc + 32'd4); end
    end
    checks++; if (cyc !== m_cyc) begin errors++; $display("FAIL seq_cycles: got %0d want %0d", cyc, m_cyc); end
  endtask

  task automatic test_branch_jalr();
    logic [31:0] b0, j0;
    jump_to(32'h100);
    b0 = m_brc; j0 = m_jmp;
    br = 1'b1; imm = -32'sd8; tick(); idle_inputs();
    checks++; if (pc !== 32'h0F8) begin errors++; $display("FAIL br_pc: got %h want 000000f8", pc); end
    checks++; if (brc !== m_brc) begin errors++; $display("FAIL br_cnt: got %0d want %0d (start %0d)", brc, m_brc, b0); end
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL br_mis: got %b want 0", mis); end
    jalr = 1'b1; rs1 = 32'h203; tick(); idle_inputs();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jalr_pc: got %h want 00000200", pc); end
    checks++; if (jmp !== m_jmp) begin errors++; $display("FAIL jalr_cnt: got %0d want %0d (start %0d)", jmp, m_jmp, j0); end
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL jalr_mis: got %b want 1", mis); end
    tick();
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b want 1", mis); end
  endtask

  task automatic test_jal_priority();
    jump_to(32'h40);
    jal = 1'b1; br = 1'b1; imm = 32'h10; tick(); idle_inputs();
    checks++; if (pc !== 32'h50) begin errors++; $display("FAIL jal_pc: got %h want 00000050", pc); end
    checks++; if ({brc, jmp} !== {m_brc, m_jmp}) begin errors++; $display("FAIL jal_cnt: got %0d/%0d want %0d/%0d", brc, jmp, m_brc, m_jmp); end
    jal = 1'b1; jalr = 1'b1; rs1 = 32'h1001; imm = 32'h20; tick(); idle_inputs();
    checks++; if (pc !== 32'h1020) begin errors++; $display("FAIL jal_jalr_pc: got %h want 00001020", pc); end
    checks++; if (jmp !== m_jmp) begin errors++; $display("FAIL jal_jalr_cnt: got %0d want %0d", jmp, m_jmp); end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    jump_to(32'h80);
    halt = 1'b1; go = 1'b1; tick(); idle_inputs();
    c0 = m_cyc;
    checks++; if ({halted, pc} !== {1'b1, 32'h80}) begin errors++; $display("FAIL halt_enter: got %b/%h want 1/00000080", halted, pc); end
    for (int i = 0; i < 5; i++) begin
      halt = 1'($urandom); br = 1'($urandom); jal = 1'($urandom); jalr = 1'($urandom);
      imm = $urandom; rs1 = $urandom; tick();
      checks++; if ({halted, pc, cyc} !== {1'b1, 32'h80, m_cyc}) begin
        errors++; $display("FAIL halt_hold%0d: got %b/%h/%0d want 1/00000080/%0d", i, halted, pc, cyc, c0);
      end
    end
    idle_inputs(); go = 1'b1; tick();
    checks++; if ({halted, pc} !== {1'b0, 32'h84}) begin errors++; $display("FAIL resume: got %b/%h want 0/00000084", halted, pc); end
    tick();
    checks++; if ({halted, pc} !== {1'b0, 32'h88}) begin errors++; $display("FAIL go_held_run: got %b/%h want 0/00000088", halted, pc); end
    halt = 1'b1; tick(); halt = 1'b0;
    checks++; if ({halted, pc} !== {1'b1, 32'h88}) begin errors++; $display("FAIL rehalt: got %b/%h want 1/00000088", halted, pc); end
    go = 1'b0; tick();
  endtask

  task automatic test_reset_halted();
    idle_inputs(); halt = 1'b1; tick(); idle_inputs();
    rst = 1'b1; go = 1'b1; tick(); idle_inputs();
    checks++; if ({pc, halted, mis} !== {RST_PC, 2'b00}) begin errors++; $display("FAIL rst_halt: got %h/%b/%b want %h/0/0", pc, halted, mis, RST_PC); end
    checks++; if ({cyc, brc, jmp} !== 96'd0) begin errors++; $display("FAIL rst_halt_cnt: got %h %h %h want 0", cyc, brc, jmp); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) < 2);
      halt = ($urandom_range(0, 99) < 8);
      go   = ($urandom_range(0, 99) < 30);
      br   = 1'($urandom); jal = ($urandom_range(0, 3) == 0); jalr = ($urandom_range(0, 3) == 0);
      imm  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      rs1  = $urandom;
      tick();
      checks++;
      if ({pc, pc4, halted, mis, cyc, brc, jmp} !== {m_pc, m_pc + 32'd4, m_halted, m_mis, m_cyc, m_brc, m_jmp}) begin
        errors++;
        $display("FAIL rand%0d: got pc=%h h=%b m=%b c=%0d b=%0d j=%0d want pc=%h h=%b m=%b c=%0d b=%0d j=%0d",
                 i, pc, halted, mis, cyc, brc, jmp, m_pc, m_halted, m_mis, m_cyc, m_brc, m_jmp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = 32'd0; m_halted = 1'b0; m_mis = 1'b0; m_cyc = 32'd0; m_brc = 32'd0; m_jmp = 32'd0;
    test_reset();
    test_branch_jalr();
    test_jal_priority();
    test_halt();
    test_reset_halted();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle RV32I core; sits directly downstream of the branch-decision AND gate (Branch & condition).
- Holds the PC, selects the next PC (sequential, taken branch, JAL, JALR) and runs a RUN/HALT state machine for ecall halt and resume.
- Keeps retire statistics for the board display: cycle, taken-branch and jump counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of each statistics counter.

Ports:
- Clock  input  1  core clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Go  input  1  resume request while halted; level or pulse.
- Halt  input  1  decoded ecall-halt for the current instruction.
- BranchTaken  input  1  AND-gate result, Branch & condition.
- Jal  input  1  current instruction is JAL.
- Jalr  input  1  current instruction is JALR.
- Imm  input  32  sign-extended immediate of the current instruction.
- Rs1Data  input  32  rs1 operand, used as the JALR base.
- Pc  output  32  current PC, fetch address.
- PcPlus4  output  32  Pc + 4, combinational; used as the link value.
- Halted  output  1  1 while in state HALT.
- Misalign  output  1  sticky flag: a redirect target had bit 1 set.
- CycleCnt  output  CNT_W  cycles spent in RUN.
- BranchCnt  output  CNT_W  taken conditional branches.
- JumpCnt  output  CNT_W  executed JAL and JALR instructions.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Values on Reset: Pc=RESET_PC, state=RUN, Halted=0, Misalign=0, all counters=0. Reset has priority over every other input in that cycle.
- Targets:
  - Branch and JAL target = Pc + Imm.
  - JALR target = (Rs1Data + Imm) & ~1.
  - All adds are 32-bit and wrap modulo 2^32.
- Next-PC priority in RUN:
  - Halt: Pc held.
  - else Jalr: JALR target.
  - else Jal: JAL target.
  - else BranchTaken: branch target.
  - else PcPlus4.
- Alignment: the loaded PC always has bits [1:0] forced to 00. If the selected redirect target has bit 1 = 1, Misalign sets and stays set until Reset.
- FSM:
  - RUN: if Halt=1, go to HALT and hold Pc on the ecall instruction. Otherwise stay in RUN and load the next PC.
  - HALT: Pc frozen; Halted=1; BranchTaken, Jal, Jalr and Halt are ignored. If Go=1, go to RUN and load Pc <= Pc+4, stepping past the ecall.
  - Go asserted in the same cycle Halt enters HALT is ignored; resume needs Go during HALT.
  - Go held high: exactly one resume occurs per HALT entry. A new Halt re-halts the core regardless of Go.
- Counters:
  - CycleCnt increments every RUN cycle, including the cycle in which Halt is sampled. It does not increment in HALT.
  - BranchCnt increments in RUN when BranchTaken=1 and neither Jal nor Jalr is set.
  - JumpCnt increments in RUN when Jal or Jalr is set.
  - No counter increments when Halt=1 in that cycle, except CycleCnt.
  - All counters wrap at 2^CNT_W.
- Simultaneous inputs: Jal and Jalr both set counts once and takes the JALR target. Pc and counter updates occur in the same edge.
- Reset mid-HALT returns the block to RUN at RESET_PC.

Optional Feature:
- Macro PC_STATS_EN.
- Defined: the three counters are implemented as specified above.
- Undefined: no counter registers are built; CycleCnt, BranchCnt and JumpCnt are tied to 0. PC and FSM behaviour are unchanged.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state encoding: ST_RUN=1'b0, ST_HALT=1'b1
  - constant PC_STEP=32'd4
  - next-PC select encoding: SEL_SEQ, SEL_BR, SEL_JAL, SEL_JALR, SEL_HOLD
- One sub-module, pc_next_mux: combinational target adders, priority select and alignment check, returning the selected PC and a misalign bit.
- Registers, FSM and counters stay in pc_sequencer.

Test Plan:
- Reset with RESET_PC=32'h0000_3000, then 3 idle RUN cycles -> Pc 3000, 3004, 3008, 300C; CycleCnt=3.
- At Pc=32'h100: BranchTaken=1, Imm=-8 -> next Pc=32'h0F8, BranchCnt=1. Next cycle Jalr=1, Rs1Data=32'h203, Imm=0 -> Pc=32'h200, JumpCnt=1, Misalign=1.
- Jal=1 with BranchTaken=1 and Imm=32'h10 at Pc=32'h40 -> Pc=32'h50, JumpCnt+1, BranchCnt unchanged.
- Halt=1 at Pc=32'h80 -> Halted=1 and Pc held at 80 for 5 cycles with CycleCnt frozen; Go=1 -> Pc=32'h84, Halted=0. Go held high through a second Halt -> halts again.
- Reset asserted while halted with Go=1 -> Pc=RESET_PC, Halted=0, counters 0, Misalign 0.
- Build without PC_STATS_EN and repeat the branch/jump scenario -> all counters read 0, PC sequence identical.
